// File: rtl/handshake_constant_check_sink.sv
// handshake_constant_check_sink
//
// Terminating sink for an elastic constant channel. Every token taken from a
// valid/ready producer is compared against the fixed EXPECTED value. The sink
// counts accepted and mismatching tokens and keeps the data of the last token.
// With a non-zero TARGET it stops accepting once TARGET tokens have arrived.
// It can also serve as an in-silicon self-check at a dataflow leaf.
//
// Parameters
//   DATA_WIDTH  width of ins / last_data
//   EXPECTED    value every token must carry
//   CNT_WIDTH   width of count / err_count
//   TARGET      tokens to accept before done; 0 = free-run, never done
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous active-high reset (has priority over clear)
//   ins        in   token data, ignored while ins_valid is low
//   ins_valid  in   producer offers a token
//   ins_ready  out  sink takes the token this cycle (registers + rst only)
//   clear      in   synchronous restart to reset values; beats a same-cycle accept
//   count      out  tokens accepted since reset/clear (wraps when TARGET = 0)
//   err_count  out  accepted tokens with ins != EXPECTED, saturating
//   last_data  out  data of the most recently accepted token
//   error      out  sticky flag, set by the first mismatch
//   done       out  TARGET tokens accepted, sink no longer ready
//
// Configuration macro
//   HANDSHAKE_SINK_STALL_EN  when defined, an 8-bit Fibonacci LFSR
//   (x^8+x^6+x^5+x^4+1, seeded with 8'h01 on rst/clear) advances every cycle.
//   Its bit 0 inserts pseudo-random back-pressure on ins_ready.

module handshake_constant_check_sink #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] EXPECTED   = '0,
    parameter int unsigned           CNT_WIDTH  = 16,
    parameter int unsigned           TARGET     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    input  logic                  clear,
    output logic [CNT_WIDTH-1:0]  count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [DATA_WIDTH-1:0] last_data,
    output logic                  error,
    output logic                  done
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam bit                   HAS_TARGET = (TARGET != 0);
    // count value at which the accepted token is the TARGET-th one
    localparam logic [CNT_WIDTH-1:0] LAST_IDX   = CNT_WIDTH'(TARGET - 1);

    state_t state;
    state_t state_next;
    logic   stall;
    logic   accept;

`ifdef HANDSHAKE_SINK_STALL_EN
    logic [7:0] lfsr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lfsr <= 8'h01;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    // Ready depends only on registers and rst, so ins_valid can never loop
    // back into ins_ready. The sink drops readiness during the reset cycle,
    // so no token is in flight when it leaves reset.
    assign ins_ready = ~rst & (state == ST_RUN) & ~stall;
    assign accept    = ins_valid & ins_ready;
    assign done      = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first. Any
    // path that leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ST_RUN;
        end else if (HAS_TARGET && state == ST_RUN && accept && count == LAST_IDX) begin
            state_next = ST_DONE;
        end
    end

    // A token accepted in the same cycle as clear still completes its
    // handshake, but the clear wins and the token leaves no trace.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count     <= '0;
            err_count <= '0;
            last_data <= '0;
            error     <= 1'b0;
        end else if (accept) begin
            count     <= count + 1'b1;
            last_data <= ins;
            if (ins != EXPECTED) begin
                error <= 1'b1;
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_handshake_constant_check_sink.sv
`timescale 1ns/1ps

module tb_handshake_constant_check_sink;

    localparam int          NI  = 3;
    localparam logic [16:0] EXP = 17'h0D0DF;
`ifdef HANDSHAKE_SINK_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    // instance 0: free-run 16-bit counters, instance 1: TARGET=4,
    // instance 2: free-run 2-bit counters
    function automatic int tgt_of(input int i);
        return (i == 1) ? 4 : 0;
    endfunction

    function automatic logic [15:0] mask_of(input int i);
        return (i == 2) ? 16'h0003 : 16'hFFFF;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [16:0] ins       [NI];
    logic        ins_valid [NI];
    logic        clear     [NI];

    logic [NI-1:0] rdy;
    logic [NI-1:0] eflag;
    logic [NI-1:0] dflag;
    logic [15:0]   c0, c1, e0, e1;
    logic [1:0]    c2, e2;
    logic [16:0]   l0, l1, l2;

    handshake_constant_check_sink #(
        .DATA_WIDTH(17), .EXPECTED(EXP), .CNT_WIDTH(16), .TARGET(0)
    ) u_free (
        .clk(clk), .rst(rst), .ins(ins[0]), .ins_valid(ins_valid[0]),
        .ins_ready(rdy[0]), .clear(clear[0]), .count(c0), .err_count(e0),
        .last_data(l0), .error(eflag[0]), .done(dflag[0])
    );

    handshake_constant_check_sink #(
        .DATA_WIDTH(17), .EXPECTED(EXP), .CNT_WIDTH(16), .TARGET(4)
    ) u_target (
        .clk(clk), .rst(rst), .ins(ins[1]), .ins_valid(ins_valid[1]),
        .ins_ready(rdy[1]), .clear(clear[1]), .count(c1), .err_count(e1),
        .last_data(l1), .error(eflag[1]), .done(dflag[1])
    );

    handshake_constant_check_sink #(
        .DATA_WIDTH(17), .EXPECTED(EXP), .CNT_WIDTH(2), .TARGET(0)
    ) u_small (
        .clk(clk), .rst(rst), .ins(ins[2]), .ins_valid(ins_valid[2]),
        .ins_ready(rdy[2]), .clear(clear[2]), .count(c2), .err_count(e2),
        .last_data(l2), .error(eflag[2]), .done(dflag[2])
    );

    function automatic logic [15:0] dut_count(input int i);
        case (i)
            0:       return c0;
            1:       return c1;
            default: return {14'b0, c2};
        endcase
    endfunction

    function automatic logic [15:0] dut_err(input int i);
        case (i)
            0:       return e0;
            1:       return e1;
            default: return {14'b0, e2};
        endcase
    endfunction

    function automatic logic [16:0] dut_last(input int i);
        case (i)
            0:       return l0;
            1:       return l1;
            default: return l2;
        endcase
    endfunction

    // reference model, stepped from the bench's own inputs only
    bit          m_done  [NI];
    logic [15:0] m_count [NI];
    logic [15:0] m_err   [NI];
    logic [16:0] m_last  [NI];
    bit          m_error [NI];
    logic [7:0]  m_lfsr  [NI];
    bit          m_rdy   [NI];
    int          acc_total [NI];

    typedef struct {
        int          idx;
        logic [15:0] count;
        logic [15:0] err;
        logic [16:0] last;
        bit          error;
        bit          done;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // One clock cycle. Compute the model's ready and accept from the inputs
    // already applied. Check ins_ready. Push the expected post-edge state, then
    // pop it and compare once the edge has passed.
    task automatic step();
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            bit          acc;
            logic [15:0] old;
            m_rdy[i] = !rst && !m_done[i] && !(STALL && m_lfsr[i][0]);
            checks++;
            if (rdy[i] !== m_rdy[i]) begin
                errors++;
                $display("FAIL ins_ready[%0d] t=%0t got %b want %b", i, $time, rdy[i], m_rdy[i]);
            end
            acc = ins_valid[i] && m_rdy[i];
            if (rst || clear[i]) begin
                m_done[i]  = 1'b0;
                m_count[i] = '0;
                m_err[i]   = '0;
                m_last[i]  = '0;
                m_error[i] = 1'b0;
                m_lfsr[i]  = 8'h01;
            end else begin
                m_lfsr[i] = {m_lfsr[i][6:0], m_lfsr[i][7] ^ m_lfsr[i][5] ^ m_lfsr[i][4] ^ m_lfsr[i][3]};
                if (acc) begin
                    old        = m_count[i];
                    m_count[i] = (m_count[i] + 16'd1) & mask_of(i);
                    m_last[i]  = ins[i];
                    if (ins[i] !== EXP) begin
                        m_error[i] = 1'b1;
                        if (m_err[i] != mask_of(i)) m_err[i] = m_err[i] + 16'd1;
                    end
                    if (tgt_of(i) != 0 && old == 16'(tgt_of(i) - 1)) m_done[i] = 1'b1;
                    acc_total[i]++;
                end
            end
            e.idx   = i;
            e.count = m_count[i];
            e.err   = m_err[i];
            e.last  = m_last[i];
            e.error = m_error[i];
            e.done  = m_done[i];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({dut_count(e.idx), dut_err(e.idx), dut_last(e.idx), eflag[e.idx], dflag[e.idx]} !==
                {e.count, e.err, e.last, e.error, e.done}) begin
                errors++;
                $display("FAIL scoreboard[%0d] t=%0t got cnt=%0d err=%0d last=%h e=%b d=%b want cnt=%0d err=%0d last=%h e=%b d=%b",
                         e.idx, $time, dut_count(e.idx), dut_err(e.idx), dut_last(e.idx), eflag[e.idx], dflag[e.idx],
                         e.count, e.err, e.last, e.error, e.done);
            end
        end
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NI; i++) begin
            ins[i]       = '0;
            ins_valid[i] = 1'b0;
            clear[i]     = 1'b0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Offer tokens on instance i until the model has accepted n of them.
    // Token number bad_at (or every token when all_bad) carries bad_val.
    task automatic send_tokens(input int i, input int n, input int bad_at,
                               input bit all_bad, input logic [16:0] bad_val);
        int start;
        int budget;
        start  = acc_total[i];
        budget = 0;
        ins_valid[i] = 1'b1;
        while (acc_total[i] - start < n && budget < 50 * n) begin
            ins[i] = (all_bad || (acc_total[i] - start) == bad_at) ? bad_val : EXP;
            step();
            budget++;
        end
        ins_valid[i] = 1'b0;
        if (acc_total[i] - start < n) begin
            checks++;
            errors++;
            $display("FAIL send_tokens[%0d] timeout got %0d want %0d", i, acc_total[i] - start, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({dut_count(i), dut_err(i), dut_last(i), eflag[i], dflag[i]} !== {16'd0, 16'd0, 17'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_values[%0d] got cnt=%0d err=%0d last=%h e=%b d=%b want all zero",
                         i, dut_count(i), dut_err(i), dut_last(i), eflag[i], dflag[i]);
            end
        end
    endtask

    task automatic test_free_run();
        do_reset();
        send_tokens(0, 10, -1, 1'b0, 17'h0);
        checks++;
        if ({c0, e0, eflag[0], l0} !== {16'd10, 16'd0, 1'b0, EXP}) begin
            errors++;
            $display("FAIL free_run got cnt=%0d err=%0d e=%b last=%h want cnt=10 err=0 e=0 last=%h",
                     c0, e0, eflag[0], l0, EXP);
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        send_tokens(0, 10, 3, 1'b0, 17'h00000);
        checks++;
        if ({c0, e0, eflag[0], l0} !== {16'd10, 16'd1, 1'b1, EXP}) begin
            errors++;
            $display("FAIL mismatch got cnt=%0d err=%0d e=%b last=%h want cnt=10 err=1 e=1 last=%h",
                     c0, e0, eflag[0], l0, EXP);
        end
        // valid low: data is ignored, even when undefined
        ins[0] = 'x;
        step();
        step();
        ins[0] = '0;
        checks++;
        if ({c0, e0, l0} !== {16'd10, 16'd1, EXP}) begin
            errors++;
            $display("FAIL valid_low_ignored got cnt=%0d err=%0d last=%h want cnt=10 err=1 last=%h",
                     c0, e0, l0, EXP);
        end
    endtask

    task automatic test_target();
        int budget;
        do_reset();
        ins[1]       = EXP;
        ins_valid[1] = 1'b1;
        budget       = 0;
        while (!m_done[1] && budget < 200) begin
            step();
            budget++;
        end
        for (int k = 0; k < 4; k++) step();
        ins_valid[1] = 1'b0;
        checks++;
        if ({c1, dflag[1], rdy[1]} !== {16'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL target_done got cnt=%0d done=%b rdy=%b want cnt=4 done=1 rdy=0", c1, dflag[1], rdy[1]);
        end
        clear[1] = 1'b1;
        step();
        clear[1] = 1'b0;
        checks++;
        if ({c1, dflag[1], rdy[1]} !== {16'd0, 1'b0, !STALL}) begin
            errors++;
            $display("FAIL target_clear got cnt=%0d done=%b rdy=%b want cnt=0 done=0 rdy=%b",
                     c1, dflag[1], rdy[1], !STALL);
        end
    endtask

    task automatic test_clear_accept();
        do_reset();
        send_tokens(0, 3, 0, 1'b0, 17'h00000);
        ins[0]       = 17'h00000;
        ins_valid[0] = 1'b1;
        clear[0]     = 1'b1;
        step();
        clear[0]     = 1'b0;
        ins_valid[0] = 1'b0;
        checks++;
        if ({c0, e0, eflag[0]} !== {16'd0, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL clear_accept got cnt=%0d err=%0d e=%b want 0 0 0", c0, e0, eflag[0]);
        end
        // rst together with clear, with a mismatching token in flight
        send_tokens(0, 2, 0, 1'b0, 17'h00005);
        ins[0]       = 17'h00005;
        ins_valid[0] = 1'b1;
        clear[0]     = 1'b1;
        rst          = 1'b1;
        step();
        rst          = 1'b0;
        clear[0]     = 1'b0;
        ins_valid[0] = 1'b0;
        checks++;
        if ({c0, e0, l0, eflag[0], dflag[0]} !== {16'd0, 16'd0, 17'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_with_clear got cnt=%0d err=%0d last=%h e=%b d=%b want all zero",
                     c0, e0, l0, eflag[0], dflag[0]);
        end
    endtask

    task automatic test_wrap_saturate();
        do_reset();
        send_tokens(2, 5, -1, 1'b1, 17'h00001);
        checks++;
        if ({c2, e2, eflag[2]} !== {2'd1, 2'd3, 1'b1}) begin
            errors++;
            $display("FAIL wrap_saturate got cnt=%0d err=%0d e=%b want cnt=1 err=3 e=1", c2, e2, eflag[2]);
        end
    endtask

    task automatic test_back_to_back();
        int n_rdy;
        do_reset();
        n_rdy        = 0;
        ins[0]       = EXP;
        ins_valid[0] = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if (!(STALL && m_lfsr[0][0])) n_rdy++;
            step();
        end
        ins_valid[0] = 1'b0;
        checks++;
        if ({c0, e0} !== {16'(n_rdy), 16'd0}) begin
            errors++;
            $display("FAIL back_to_back got cnt=%0d err=%0d want cnt=%0d err=0", c0, e0, n_rdy);
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_done[i]    = 1'b0;
            m_count[i]   = '0;
            m_err[i]     = '0;
            m_last[i]    = '0;
            m_error[i]   = 1'b0;
            m_lfsr[i]    = 8'h01;
            acc_total[i] = 0;
        end
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_free_run();
        test_mismatch();
        test_target();
        test_clear_accept();
        test_wrap_saturate();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
